// File: rtl/avalon_aip_fifo.sv
// -----------------------------------------------------------------------------
// avalon_aip_fifo
// Avalon-MM slave bridging a Nios master to one AIP core. Write data is queued
// in a TX FIFO that drains one word per cycle into the core whenever the core
// is not busy. A start request is deferred until the FIFO has fully drained.
// The block also provides a status register and a maskable interrupt.
//
// Register map (full-width byte address compare, unmapped reads return 0):
//   0x00 DATA_OUT (R)   core result; o_aip_read is pulsed during the access
//   0x04 DATA_IN  (W)   push into the TX FIFO
//   0x08 CONFIG   (R/W) low CFG_W bits drive o_aip_config
//   0x0C CTRL     (W)   bit1 flush, bit0 start request
//   0x10 STATUS   (R)   [0] empty [1] full [2] ovf [3] start pending
//                       [4] irq pending [8+:LVL_W] count; write bit2 clears ovf
//   0x14 IRQ      (R/W) [0] pending (write 1 clears), [1] enable
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_avalon_*                   Avalon-MM slave inputs
//   o_avalon_readdata/valid      registered read response, latency 1
//   i_aip_dataOut, o_aip_read    core result word and its pop strobe
//   i_aip_busy                   core cannot accept a data word
//   o_aip_dataIn, o_aip_write    registered data word and push pulse
//   o_aip_config                 CONFIG[CFG_W-1:0]
//   o_aip_start                  registered start pulse
//   i_aip_int, o_core_int        core interrupt in, masked interrupt out
//
// Build option: define AVALON_AIP_IRQ_EDGE_EN to latch rising edges of
// i_aip_int into a sticky pending bit; otherwise pending follows i_aip_int.
// -----------------------------------------------------------------------------
module avalon_aip_fifo #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int CFG_W      = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_avalon_address,
    input  logic              i_avalon_chipselect,
    input  logic              i_avalon_write,
    input  logic              i_avalon_read,
    input  logic [DATA_W-1:0] i_avalon_writedata,
    output logic [DATA_W-1:0] o_avalon_readdata,
    output logic              o_avalon_readdatavalid,
    input  logic [DATA_W-1:0] i_aip_dataOut,
    input  logic              i_aip_busy,
    output logic [DATA_W-1:0] o_aip_dataIn,
    output logic [CFG_W-1:0]  o_aip_config,
    output logic              o_aip_read,
    output logic              o_aip_write,
    output logic              o_aip_start,
    input  logic              i_aip_int,
    output logic              o_core_int
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [ADDR_W-1:0] A_DATA_OUT = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] A_DATA_IN  = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] A_CONFIG   = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(32'h0C);
    localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(32'h10);
    localparam logic [ADDR_W-1:0] A_IRQ      = ADDR_W'(32'h14);
    localparam logic [LVL_W-1:0]  LVL_FULL   = LVL_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  count_r;
    logic [LVL_W-1:0]  count_nxt_s;
    logic [DATA_W-1:0] config_r;
    logic              ovf_r;
    logic              start_pend_r;
    logic              start_pend_nxt_s;
    logic              irq_en_r;
    logic              irq_pend_s;
    logic [DATA_W-1:0] readdata_r;
    logic              readdatavalid_r;
    logic [DATA_W-1:0] aip_data_r;
    logic              aip_write_r;
    logic              aip_start_r;
    logic [DATA_W-1:0] rd_mux_s;
    logic [DATA_W-1:0] status_s;

    // A simultaneous read and write strobe is handled as a write only.
    logic acc_wr_s, acc_rd_s;
    assign acc_wr_s = i_avalon_chipselect & i_avalon_write;
    assign acc_rd_s = i_avalon_chipselect & i_avalon_read & ~i_avalon_write;

    logic push_req_s, flush_s, start_req_s, ovf_clr_s, cfg_wr_s, irq_wr_s;
    assign push_req_s  = acc_wr_s & (i_avalon_address == A_DATA_IN);
    assign flush_s     = acc_wr_s & (i_avalon_address == A_CTRL) & i_avalon_writedata[1];
    assign start_req_s = acc_wr_s & (i_avalon_address == A_CTRL) & i_avalon_writedata[0];
    assign ovf_clr_s   = acc_wr_s & (i_avalon_address == A_STATUS) & i_avalon_writedata[2];
    assign cfg_wr_s    = acc_wr_s & (i_avalon_address == A_CONFIG);
    assign irq_wr_s    = acc_wr_s & (i_avalon_address == A_IRQ);

    logic fifo_empty_s, fifo_full_s, pop_s, push_ok_s, ovf_set_s;
    assign fifo_empty_s = (count_r == LVL_W'(0));
    assign fifo_full_s  = (count_r == LVL_W'(LVL_FULL));
    // A flush discards everything, including any word that would drain this cycle.
    assign pop_s        = ~fifo_empty_s & ~i_aip_busy & ~flush_s;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok_s    = push_req_s & ~flush_s & (~fifo_full_s | pop_s);
    assign ovf_set_s    = push_req_s & ~flush_s & ~push_ok_s;

    // Start fires immediately on an empty (or just-flushed) FIFO; otherwise it
    // waits until the count reaches zero, which is the cycle the final word is
    // presented on o_aip_write, so the pulse lands one cycle after that word.
    logic start_now_s, start_drain_s, start_fire_s;
    assign start_now_s   = start_req_s & (fifo_empty_s | flush_s) & ~push_ok_s;
    assign start_drain_s = start_pend_r & fifo_empty_s & ~push_ok_s & ~flush_s;
    assign start_fire_s  = start_now_s | start_drain_s;

    // FIFO occupancy and pending-start next-state.
    always_comb begin
        count_nxt_s      = count_r;
        start_pend_nxt_s = start_pend_r;
        if (flush_s) begin
            count_nxt_s = LVL_W'(0);
        end else if (push_ok_s && !pop_s) begin
            count_nxt_s = count_r + LVL_W'(1);
        end else if (pop_s && !push_ok_s) begin
            count_nxt_s = count_r - LVL_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
        if (flush_s || start_fire_s) begin
            start_pend_nxt_s = 1'b0;
        end else if (start_req_s) begin
            start_pend_nxt_s = 1'b1;
        end else begin
            start_pend_nxt_s = start_pend_r;
        end
    end

    // Readback multiplexer; write-only and unmapped addresses return zero.
    always_comb begin
        status_s              = DATA_W'(0);
        status_s[0]           = fifo_empty_s;
        status_s[1]           = fifo_full_s;
        status_s[2]           = ovf_r;
        status_s[3]           = start_pend_r;
        status_s[4]           = irq_pend_s;
        status_s[8 +: LVL_W]  = count_r;
        rd_mux_s              = DATA_W'(0);
        case (i_avalon_address)
            A_DATA_OUT: rd_mux_s = i_aip_dataOut;
            A_CONFIG:   rd_mux_s = config_r;
            A_STATUS:   rd_mux_s = status_s;
            A_IRQ:      rd_mux_s = DATA_W'({irq_en_r, irq_pend_s});
            default:    rd_mux_s = DATA_W'(0);
        endcase
    end

    // FIFO storage, pointers and the registered AIP/Avalon outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= DATA_W'(0);
            end
            wr_ptr_r        <= PTR_W'(0);
            rd_ptr_r        <= PTR_W'(0);
            count_r         <= LVL_W'(0);
            config_r        <= DATA_W'(0);
            ovf_r           <= 1'b0;
            start_pend_r    <= 1'b0;
            irq_en_r        <= 1'b0;
            readdata_r      <= DATA_W'(0);
            readdatavalid_r <= 1'b0;
            aip_data_r      <= DATA_W'(0);
            aip_write_r     <= 1'b0;
            aip_start_r     <= 1'b0;
        end else begin
            if (push_ok_s) begin
                fifo_mem_r[wr_ptr_r] <= i_avalon_writedata;
            end
            if (flush_s) begin
                wr_ptr_r <= PTR_W'(0);
                rd_ptr_r <= PTR_W'(0);
            end else begin
                if (push_ok_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
            end
            count_r      <= count_nxt_s;
            start_pend_r <= start_pend_nxt_s;
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end
            if (cfg_wr_s) begin
                config_r <= i_avalon_writedata;
            end
            if (irq_wr_s) begin
                irq_en_r <= i_avalon_writedata[1];
            end
            readdatavalid_r <= acc_rd_s;
            if (acc_rd_s) begin
                readdata_r <= rd_mux_s;
            end
            aip_write_r <= pop_s;
            if (pop_s) begin
                aip_data_r <= fifo_mem_r[rd_ptr_r];
            end
            aip_start_r <= start_fire_s;
        end
    end

`ifdef AVALON_AIP_IRQ_EDGE_EN
    logic int_d_r;
    logic irq_pend_r;
    logic irq_clr_s;
    assign irq_clr_s = irq_wr_s & i_avalon_writedata[0];

    // Sticky edge-detected interrupt; a new edge wins over a coincident clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            int_d_r    <= 1'b0;
            irq_pend_r <= 1'b0;
        end else begin
            int_d_r <= i_aip_int;
            if (i_aip_int && !int_d_r) begin
                irq_pend_r <= 1'b1;
            end else if (irq_clr_s) begin
                irq_pend_r <= 1'b0;
            end
        end
    end
    assign irq_pend_s = irq_pend_r;
`else
    assign irq_pend_s = i_aip_int;
`endif

    assign o_avalon_readdata      = readdata_r;
    assign o_avalon_readdatavalid = readdatavalid_r;
    assign o_aip_dataIn           = aip_data_r;
    assign o_aip_write            = aip_write_r;
    assign o_aip_start            = aip_start_r;
    assign o_aip_config           = config_r[CFG_W-1:0];
    assign o_aip_read             = acc_rd_s & (i_avalon_address == A_DATA_OUT);
    assign o_core_int             = irq_pend_s & irq_en_r;

endmodule
